// File: rtl/coin_pkg.sv
// -----------------------------------------------------------------------------
// coin_pkg
// Shared definitions for the coin validator and its consumers (e.g. the coin
// casher): coin code enum, validator FSM state enum, per-coin acceptance
// windows (diameter / mass, ADC units, inclusive) and a window-match helper.
// -----------------------------------------------------------------------------
package coin_pkg;

    // Coin codes as seen on inserted_coin.
    typedef enum logic [2:0] {
        NONE    = 3'b000,
        NICKEL  = 3'b001,
        DIME    = 3'b010,
        QUARTER = 3'b011,
        DOLLAR  = 3'b100,
        TOONIE  = 3'b101,
        INVALID = 3'b111
    } coin_code_e;

    // Validator FSM states; also exported on the validator debug port.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DEBOUNCE   = 3'd1,
        SAMPLE     = 3'd2,
        CLASSIFY   = 3'd3,
        EMIT       = 3'd4,
        WAIT_CLEAR = 3'd5,
        HOLDOFF    = 3'd6
    } vld_state_e;

    // Acceptance windows, inclusive on both ends.
    localparam logic [7:0] NICKEL_DIAM_MIN  = 8'd168;
    localparam logic [7:0] NICKEL_DIAM_MAX  = 8'd178;
    localparam logic [7:0] NICKEL_MASS_MIN  = 8'd75;
    localparam logic [7:0] NICKEL_MASS_MAX  = 8'd85;

    localparam logic [7:0] DIME_DIAM_MIN    = 8'd140;
    localparam logic [7:0] DIME_DIAM_MAX    = 8'd150;
    localparam logic [7:0] DIME_MASS_MIN    = 8'd28;
    localparam logic [7:0] DIME_MASS_MAX    = 8'd40;

    localparam logic [7:0] QUARTER_DIAM_MIN = 8'd186;
    localparam logic [7:0] QUARTER_DIAM_MAX = 8'd196;
    localparam logic [7:0] QUARTER_MASS_MIN = 8'd68;
    localparam logic [7:0] QUARTER_MASS_MAX = 8'd78;

    localparam logic [7:0] DOLLAR_DIAM_MIN  = 8'd207;
    localparam logic [7:0] DOLLAR_DIAM_MAX  = 8'd217;
    localparam logic [7:0] DOLLAR_MASS_MIN  = 8'd130;
    localparam logic [7:0] DOLLAR_MASS_MAX  = 8'd150;

    localparam logic [7:0] TOONIE_DIAM_MIN  = 8'd218;
    localparam logic [7:0] TOONIE_DIAM_MAX  = 8'd230;
    localparam logic [7:0] TOONIE_MASS_MIN  = 8'd165;
    localparam logic [7:0] TOONIE_MASS_MAX  = 8'd185;

    typedef struct packed {
        logic [7:0] diam_min;
        logic [7:0] diam_max;
        logic [7:0] mass_min;
        logic [7:0] mass_max;
    } coin_window_t;

    localparam coin_window_t NICKEL_WIN  = '{diam_min: NICKEL_DIAM_MIN,  diam_max: NICKEL_DIAM_MAX,
                                            mass_min: NICKEL_MASS_MIN,  mass_max: NICKEL_MASS_MAX};
    localparam coin_window_t DIME_WIN    = '{diam_min: DIME_DIAM_MIN,    diam_max: DIME_DIAM_MAX,
                                            mass_min: DIME_MASS_MIN,    mass_max: DIME_MASS_MAX};
    localparam coin_window_t QUARTER_WIN = '{diam_min: QUARTER_DIAM_MIN, diam_max: QUARTER_DIAM_MAX,
                                            mass_min: QUARTER_MASS_MIN, mass_max: QUARTER_MASS_MAX};
    localparam coin_window_t DOLLAR_WIN  = '{diam_min: DOLLAR_DIAM_MIN,  diam_max: DOLLAR_DIAM_MAX,
                                            mass_min: DOLLAR_MASS_MIN,  mass_max: DOLLAR_MASS_MAX};
    localparam coin_window_t TOONIE_WIN  = '{diam_min: TOONIE_DIAM_MIN,  diam_max: TOONIE_DIAM_MAX,
                                            mass_min: TOONIE_MASS_MIN,  mass_max: TOONIE_MASS_MAX};

    // True when both measurements fall inside the window (inclusive).
    function automatic logic in_window(input logic [7:0] diam,
                                       input logic [7:0] mass,
                                       input coin_window_t win);
        return (diam >= win.diam_min) && (diam <= win.diam_max) &&
               (mass >= win.mass_min) && (mass <= win.mass_max);
    endfunction

endpackage

// File: rtl/coin_classifier.sv
// -----------------------------------------------------------------------------
// coin_classifier
// Purely combinational: maps averaged diameter / mass to a coin code. Windows
// are tested in code order NICKEL..TOONIE and the first match wins; no match
// yields INVALID.
//
// Ports
//   avg_diam  in  [7:0]  averaged diameter (ADC units)
//   avg_mass  in  [7:0]  averaged mass (ADC units)
//   code      out [2:0]  coin code (coin_code_e)
// -----------------------------------------------------------------------------
module coin_classifier
    import coin_pkg::*;
(
    input  logic [7:0] avg_diam,
    input  logic [7:0] avg_mass,
    output coin_code_e code
);

    always_comb begin
        code = INVALID;
        if (in_window(avg_diam, avg_mass, NICKEL_WIN)) begin
            code = NICKEL;
        end else if (in_window(avg_diam, avg_mass, DIME_WIN)) begin
            code = DIME;
        end else if (in_window(avg_diam, avg_mass, QUARTER_WIN)) begin
            code = QUARTER;
        end else if (in_window(avg_diam, avg_mass, DOLLAR_WIN)) begin
            code = DOLLAR;
        end else if (in_window(avg_diam, avg_mass, TOONIE_WIN)) begin
            code = TOONIE;
        end
    end

endmodule

// File: rtl/coin_validator.sv
// -----------------------------------------------------------------------------
// coin_validator
// Synchronizes the raw coin sensor, debounces it, averages four diameter and
// mass samples, classifies the coin and emits a one-cycle result pulse. After
// the coin leaves the chute a hold-off interval is enforced before the next
// coin can be accepted.
//
// Handshake: there is no back-pressure. coin_insert / coin_unknown are
// single-cycle valid strobes (never both high); inserted_coin is valid in the
// strobe cycle and holds its value until the next strobe or reset.
//
// Ports
//   clk            in       system clock, rising edge
//   reset          in       synchronous, active-high
//   coin_present   in       raw asynchronous chute sensor
//   coin_diam      in [7:0] diameter, valid while coin present
//   coin_mass      in [7:0] mass, valid while coin present
//   coin_insert    out      one-cycle pulse: recognised coin
//   inserted_coin  out [2:0] coin code, updated only with a result pulse
//   coin_unknown   out      one-cycle pulse: no window matched
//   busy           out      high whenever the FSM is not IDLE
//   dbg_state      out [2:0] current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module coin_validator
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_present,
    input  logic [7:0] coin_diam,
    input  logic [7:0] coin_mass,
    output logic       coin_insert,
    output logic [2:0] inserted_coin,
    output logic       coin_unknown,
    output logic       busy,
    output vld_state_e dbg_state
);

    // One counter is shared by DEBOUNCE and HOLDOFF; size it for the larger.
    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ?
                                      DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Counter value on the final cycle of each timed state.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    vld_state_e       state_q,         state_d;
    logic             sync1_q,         sync1_d;
    logic             sync2_q,         sync2_d;
    logic [CNT_W-1:0] cnt_q,           cnt_d;
    logic [1:0]       samp_cnt_q,      samp_cnt_d;
    logic [9:0]       diam_sum_q,      diam_sum_d;
    logic [9:0]       mass_sum_q,      mass_sum_d;
    logic             coin_insert_q,   coin_insert_d;
    logic             coin_unknown_q,  coin_unknown_d;
    coin_code_e       inserted_coin_q, inserted_coin_d;
    logic             busy_q,          busy_d;

    logic             sync_present;
    logic [7:0]       avg_diam;
    logic [7:0]       avg_mass;
    coin_code_e       class_code;

    assign sync_present = sync2_q;

    // Average of four samples: divide by four, truncating.
    assign avg_diam = 8'(diam_sum_q >> 2);
    assign avg_mass = 8'(mass_sum_q >> 2);

    coin_classifier u_classifier (
        .avg_diam (avg_diam),
        .avg_mass (avg_mass),
        .code     (class_code)
    );

    always_comb begin
        sync1_d         = coin_present;
        sync2_d         = sync1_q;
        state_d         = state_q;
        cnt_d           = cnt_q;
        samp_cnt_d      = samp_cnt_q;
        diam_sum_d      = diam_sum_q;
        mass_sum_d      = mass_sum_q;
        inserted_coin_d = inserted_coin_q;
        // Result strobes are asserted for exactly one cycle by default.
        coin_insert_d   = 1'b0;
        coin_unknown_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (sync_present) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                end
            end

            DEBOUNCE: begin
                if (!sync_present) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = SAMPLE;
                    cnt_d      = '0;
                    samp_cnt_d = '0;
                    diam_sum_d = '0;
                    mass_sum_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SAMPLE: begin
                if (!sync_present) begin
                    // Coin left mid-measurement: drop the partial sums.
                    state_d    = IDLE;
                    samp_cnt_d = '0;
                    diam_sum_d = '0;
                    mass_sum_d = '0;
                end else begin
                    diam_sum_d = diam_sum_q + {2'b00, coin_diam};
                    mass_sum_d = mass_sum_q + {2'b00, coin_mass};
                    samp_cnt_d = samp_cnt_q + 2'd1;
                    if (samp_cnt_q == 2'd3) begin
                        state_d = CLASSIFY;
                    end
                end
            end

            CLASSIFY: begin
                // Result is registered so the strobe and code appear together
                // in the EMIT cycle.
                state_d         = EMIT;
                inserted_coin_d = class_code;
                coin_insert_d   = (class_code != INVALID);
                coin_unknown_d  = (class_code == INVALID);
            end

            EMIT: begin
                state_d = WAIT_CLEAR;
            end

            WAIT_CLEAR: begin
                if (!sync_present) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end
            end

            HOLDOFF: begin
                // The sensor is ignored here; a coin still present when the
                // interval ends is picked up from IDLE as a new coin.
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            cnt_q           <= '0;
            samp_cnt_q      <= '0;
            diam_sum_q      <= '0;
            mass_sum_q      <= '0;
            coin_insert_q   <= 1'b0;
            coin_unknown_q  <= 1'b0;
            inserted_coin_q <= NONE;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            cnt_q           <= cnt_d;
            samp_cnt_q      <= samp_cnt_d;
            diam_sum_q      <= diam_sum_d;
            mass_sum_q      <= mass_sum_d;
            coin_insert_q   <= coin_insert_d;
            coin_unknown_q  <= coin_unknown_d;
            inserted_coin_q <= inserted_coin_d;
            busy_q          <= busy_d;
        end
    end

    assign coin_insert   = coin_insert_q;
    assign coin_unknown  = coin_unknown_q;
    assign inserted_coin = inserted_coin_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_coin_validator.sv
// -----------------------------------------------------------------------------
// tb_coin_validator
// Coin stimulus is driven cycle by cycle; for every coin that should produce a
// result the expected {emit cycle, unknown flag, code} is pushed to exp_q when
// the coin is issued. An independent monitor pops on every result strobe and
// also checks code hold, strobe exclusivity and post-reset output values.
// Timing reference: edge 0 is the first rising edge that samples
// coin_present high from IDLE; the result strobe is visible after edge 11, and
// the four averaged samples are the values present at edges 7..10.
// -----------------------------------------------------------------------------
module tb_coin_validator;
    import coin_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int LAT  = 2 + DEB + 4 + 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       coin_present;
    logic [7:0] coin_diam;
    logic [7:0] coin_mass;
    logic       coin_insert;
    logic [2:0] inserted_coin;
    logic       coin_unknown;
    logic       busy;
    vld_state_e dbg_state;

    coin_validator #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLDOFF_CYCLES  (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_present  (coin_present),
        .coin_diam     (coin_diam),
        .coin_mass     (coin_mass),
        .coin_insert   (coin_insert),
        .inserted_coin (inserted_coin),
        .coin_unknown  (coin_unknown),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int   cyc      = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    int win_dmin[5] = '{168, 140, 186, 207, 218};
    int win_dmax[5] = '{178, 150, 196, 217, 230};
    int win_mmin[5] = '{ 75,  28,  68, 130, 165};
    int win_mmax[5] = '{ 85,  40,  78, 150, 185};

    function automatic int ref_code(input int ad, input int am);
        for (int i = 0; i < 5; i++) begin
            if (ad >= win_dmin[i] && ad <= win_dmax[i] &&
                am >= win_mmin[i] && am <= win_mmax[i]) return i + 1;
        end
        return 7;
    endfunction

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [19:0] exp_q[$];
    logic [2:0]  held_exp = 3'b000;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] e;
        if (rst_seen) begin
            mon_en   = 1'b1;
            held_exp = 3'b000;
            check("rst_insert",  int'(coin_insert),   0);
            check("rst_unknown", int'(coin_unknown),  0);
            check("rst_busy",    int'(busy),          0);
            check("rst_code",    int'(inserted_coin), 0);
            check("rst_state",   int'(dbg_state),     int'(IDLE));
        end else if (mon_en) begin
            check("pulse_exclusive", int'(coin_insert & coin_unknown), 0);
            if (coin_insert || coin_unknown) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got code %0d expected no pulse (cycle %0d)",
                             inserted_coin, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_insert",  int'(coin_insert),   int'(!e[3]));
                    check("pulse_unknown", int'(coin_unknown),  int'(e[3]));
                    check("pulse_code",    int'(inserted_coin), int'(e[2:0]));
                    if (e[19:4] != 16'd0) check("emit_cycle", int'(cyc[15:0]), int'(e[19:4]));
                    held_exp = e[2:0];
                end
            end else begin
                check("code_hold", int'(inserted_coin), int'(held_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    int samp_d[4];
    int samp_m[4];

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    task automatic set_coin(input int d, input int m);
        for (int i = 0; i < 4; i++) begin
            samp_d[i] = d;
            samp_m[i] = m;
        end
    endtask

    // kind 0..4: inside window kind (samples jittered by +/-1); kind 5: random.
    task automatic pick_coin(input int kind);
        int bd, bm;
        if (kind < 5) begin
            bd = int'($urandom_range(win_dmax[kind], win_dmin[kind]));
            bm = int'($urandom_range(win_mmax[kind], win_mmin[kind]));
            for (int i = 0; i < 4; i++) begin
                samp_d[i] = clamp8(bd + int'($urandom_range(2, 0)) - 1);
                samp_m[i] = clamp8(bm + int'($urandom_range(2, 0)) - 1);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                samp_d[i] = int'($urandom_range(255, 0));
                samp_m[i] = int'($urandom_range(255, 0));
            end
        end
    endtask

    // Hold the coin for n_high edges. rst_at >= 0 pulses reset at that edge and
    // removes the coin. lat > 0 checks the strobe arrives lat edges after edge 0.
    task automatic run_coin(input int n_high, input int rst_at, input int lat);
        int          sd, sm, code, start;
        logic [15:0] ec;
        logic        unk;
        sd = 0;
        sm = 0;
        for (int i = 0; i < 4; i++) begin
            sd += samp_d[i];
            sm += samp_m[i];
        end
        code = ref_code(sd / 4, sm / 4);
        @(negedge clk);
        start = cyc + 1;
        // The coin must stay present through the last sample edge (sync lag 2).
        if (rst_at < 0 && n_high >= 9) begin
            ec  = (lat > 0) ? 16'(start + lat) : 16'd0;
            unk = (code == 7);
            exp_q.push_back({ec, unk, 3'(code)});
        end
        for (int k = 0; k < n_high; k++) begin
            if (k > 0) @(negedge clk);
            coin_present = 1'b1;
            if (k >= 7 && k <= 10) begin
                coin_diam = 8'(samp_d[k-7]);
                coin_mass = 8'(samp_m[k-7]);
            end else begin
                coin_diam = 8'(samp_d[0]);
                coin_mass = 8'(samp_m[0]);
            end
            if (k == rst_at) begin
                reset = 1'b1;
                break;
            end
        end
        @(negedge clk);
        reset        = 1'b0;
        coin_present = 1'b0;
        coin_diam    = 8'($urandom);
        coin_mass    = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int v[4];
        coin_present = 1'b0;
        coin_diam    = 8'd0;
        coin_mass    = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Dollar held 20 cycles, fixed latency.
        set_coin(212, 140);
        run_coin(20, -1, LAT);
        idle(14);

        // Short presence: no result, busy drops, code holds (monitor).
        run_coin(3, -1, 0);
        idle(10);
        check("short_busy", int'(busy), 0);
        for (int r = 0; r < 4; r++) begin
            run_coin(int'($urandom_range(7, 1)), -1, 0);
            idle(10);
            check("short_rand_busy", int'(busy), 0);
        end

        // Unknown coin.
        set_coin(100, 100);
        run_coin(20, -1, LAT);
        idle(14);

        // Averaging with truncation: (170+171+172+174)/4 = 171 -> nickel.
        samp_d = '{170, 171, 172, 174};
        samp_m = '{80, 80, 80, 80};
        run_coin(18, -1, LAT);
        idle(14);

        // Second coin 4 cycles after removal: removal edge is 4 before its
        // edge 0; sync (2) + hold-off brings IDLE to edge 2+HOLD-4, then one
        // IDLE edge plus debounce, sample and classify.
        set_coin(190, 72);
        run_coin(18, -1, LAT);
        idle(3);
        run_coin(30, -1, (2 + HOLD - 4) + 1 + DEB + 4 + 1);
        idle(16);

        // Reset during SAMPLE and on the emit edge: no strobe, then normal coin.
        set_coin(145, 33);
        run_coin(20, 8, 0);
        idle(4);
        run_coin(20, LAT, 0);
        idle(4);
        run_coin(20, -1, LAT);
        idle(14);

        // Window boundaries: min, max, min-1, max+1 on each dimension.
        for (int w = 0; w < 5; w++) begin
            for (int dim = 0; dim < 2; dim++) begin
                if (dim == 0) v = '{win_dmin[w], win_dmax[w], win_dmin[w] - 1, win_dmax[w] + 1};
                else          v = '{win_mmin[w], win_mmax[w], win_mmin[w] - 1, win_mmax[w] + 1};
                for (int b = 0; b < 4; b++) begin
                    if (dim == 0) set_coin(v[b], (win_mmin[w] + win_mmax[w]) / 2);
                    else          set_coin((win_dmin[w] + win_dmax[w]) / 2, v[b]);
                    run_coin(int'($urandom_range(22, 14)), -1, LAT);
                    idle(14);
                end
            end
        end

        // Randomized coins.
        for (int r = 0; r < 40; r++) begin
            pick_coin(int'($urandom_range(5, 0)));
            run_coin(int'($urandom_range(26, 14)), -1, LAT);
            idle(int'($urandom_range(20, 14)));
        end

        idle(20);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
